// File: rtl/bf_exec_ctrl.sv
// Execution controller for the dekatron Brainfuck machine: decodes Encoder opcodes
// into registered counter step pulses, scans for matching brackets, and runs I/O handshakes.
module bf_exec_ctrl #(
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned LOOP_WIDTH  = 7,
  parameter int unsigned MAX_DEPTH   = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic       data_zero,
  input  logic       ip_zero,
  input  logic       out_ready,
  input  logic       in_ack,
  output logic       ip_up,
  output logic       ip_down,
  output logic       loop_up,
  output logic       loop_down,
  output logic       ap_up,
  output logic       ap_down,
  output logic       data_inc,
  output logic       data_dec,
  output logic       data_load,
  output logic       out_strobe,
  output logic       in_req,
  output logic       busy,
  output logic       halted,
  output logic       error
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OUT_WAIT, S_IN_WAIT,
    S_SCAN_FWD_FETCH, S_SCAN_FWD, S_SCAN_BK_FETCH, S_SCAN_BK, S_HALTED
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_INC = 4'd1, OP_DEC = 4'd2, OP_RIGHT = 4'd3, OP_LEFT = 4'd4,
    OP_OPEN = 4'd5, OP_CLOSE = 4'd6, OP_OUT = 4'd7, OP_IN = 4'd8, OP_HALT = 4'd15
  } op_t;

  typedef struct packed {
    logic ip_up, ip_down, loop_up, loop_down, ap_up, ap_down;
    logic data_inc, data_dec, data_load, out_strobe;
  } pulses_t;

  localparam logic [3:0]            LAT_LAST  = 4'(ROM_LATENCY - 1);
  localparam logic [LOOP_WIDTH-1:0] DEPTH_MAX = LOOP_WIDTH'(MAX_DEPTH);
  localparam logic [LOOP_WIDTH-1:0] DEPTH_ONE = LOOP_WIDTH'(1);

  state_t                state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [LOOP_WIDTH-1:0] depth_q, depth_d;
  logic                  error_q, error_d;
  logic                  in_req_q;
  pulses_t               pls_q, pls_d;
  logic                  depth_full;

  // Saturate at the all-ones value as well so the counter can never wrap.
  assign depth_full = (depth_q >= DEPTH_MAX) || (depth_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      depth_q  <= '0;
      error_q  <= 1'b0;
      in_req_q <= 1'b0;
      pls_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      depth_q  <= depth_d;
      error_q  <= error_d;
      in_req_q <= (state_d == S_IN_WAIT);
      pls_q    <= pls_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    depth_d = depth_q;
    error_d = error_q;
    pls_d   = '0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH, S_SCAN_FWD_FETCH, S_SCAN_BK_FETCH: begin
        if (wait_q == LAT_LAST) begin
          wait_d = '0;
          state_d = (state_q == S_FETCH)          ? S_DECODE   :
                    (state_q == S_SCAN_FWD_FETCH) ? S_SCAN_FWD : S_SCAN_BK;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_INC:   begin pls_d.data_inc = 1'b1; pls_d.ip_up = 1'b1; state_d = S_FETCH; end
          OP_DEC:   begin pls_d.data_dec = 1'b1; pls_d.ip_up = 1'b1; state_d = S_FETCH; end
          OP_RIGHT: begin pls_d.ap_up    = 1'b1; pls_d.ip_up = 1'b1; state_d = S_FETCH; end
          OP_LEFT:  begin pls_d.ap_down  = 1'b1; pls_d.ip_up = 1'b1; state_d = S_FETCH; end
          OP_OUT: begin
            if (out_ready) begin
              pls_d.out_strobe = 1'b1;
              pls_d.ip_up      = 1'b1;
              state_d          = S_FETCH;
            end else begin
              state_d = S_OUT_WAIT;
            end
          end
          OP_IN: state_d = S_IN_WAIT;
          OP_OPEN: begin
            pls_d.ip_up = 1'b1;
            if (!data_zero) begin
              state_d = S_FETCH;
            end else begin
              depth_d       = DEPTH_ONE;
              pls_d.loop_up = 1'b1;
              state_d       = S_SCAN_FWD_FETCH;
            end
          end
          OP_CLOSE: begin
            if (data_zero) begin
              pls_d.ip_up = 1'b1;
              state_d     = S_FETCH;
            end else begin
              depth_d       = DEPTH_ONE;
              pls_d.loop_up = 1'b1;
              pls_d.ip_down = 1'b1;
              state_d       = S_SCAN_BK_FETCH;
            end
          end
          OP_HALT: state_d = S_HALTED;
          default: begin pls_d.ip_up = 1'b1; state_d = S_FETCH; end
        endcase
      end
      S_OUT_WAIT: begin
        if (out_ready) begin
          pls_d.out_strobe = 1'b1;
          pls_d.ip_up      = 1'b1;
          state_d          = S_FETCH;
        end
      end
      S_IN_WAIT: begin
        if (in_ack) begin
          pls_d.data_load = 1'b1;
          pls_d.ip_up     = 1'b1;
          state_d         = S_FETCH;
        end
      end
      S_SCAN_FWD: begin
        state_d = S_SCAN_FWD_FETCH;
        case (opcode)
          OP_OPEN: begin
            if (depth_full) begin
              error_d = 1'b1;
              state_d = S_HALTED;
            end else begin
              depth_d       = depth_q + DEPTH_ONE;
              pls_d.loop_up = 1'b1;
              pls_d.ip_up   = 1'b1;
            end
          end
          OP_CLOSE: begin
            depth_d         = depth_q - DEPTH_ONE;
            pls_d.loop_down = 1'b1;
            pls_d.ip_up     = 1'b1;
            if (depth_q == DEPTH_ONE) state_d = S_FETCH;
          end
          OP_HALT: begin
            error_d = 1'b1;
            state_d = S_HALTED;
          end
          default: pls_d.ip_up = 1'b1;
        endcase
      end
      S_SCAN_BK: begin
        state_d = S_SCAN_BK_FETCH;
        case (opcode)
          OP_CLOSE: begin
            if (depth_full) begin
              error_d = 1'b1;
              state_d = S_HALTED;
            end else begin
              depth_d       = depth_q + DEPTH_ONE;
              pls_d.loop_up = 1'b1;
              pls_d.ip_down = 1'b1;
            end
          end
          OP_OPEN: begin
            depth_d         = depth_q - DEPTH_ONE;
            pls_d.loop_down = 1'b1;
            // The matching '[' steps forward so execution resumes just past it.
            if (depth_q == DEPTH_ONE) begin
              pls_d.ip_up = 1'b1;
              state_d     = S_FETCH;
            end else begin
              pls_d.ip_down = 1'b1;
            end
          end
          default: begin
            if (ip_zero) begin
              error_d = 1'b1;
              state_d = S_HALTED;
            end else begin
              pls_d.ip_down = 1'b1;
            end
          end
        endcase
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  assign ip_up      = pls_q.ip_up;
  assign ip_down    = pls_q.ip_down;
  assign loop_up    = pls_q.loop_up;
  assign loop_down  = pls_q.loop_down;
  assign ap_up      = pls_q.ap_up;
  assign ap_down    = pls_q.ap_down;
  assign data_inc   = pls_q.data_inc;
  assign data_dec   = pls_q.data_dec;
  assign data_load  = pls_q.data_load;
  assign out_strobe = pls_q.out_strobe;
  assign in_req     = in_req_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted     = (state_q == S_HALTED);
  assign error      = error_q;

endmodule

// File: tb/tb_bf_exec_ctrl.sv
// Bench for bf_exec_ctrl: closed-loop program memory, data tape and I/O around the DUT,
// checked against a Brainfuck-level interpreter that predicts pulse totals and output bytes.
module tb_bf_exec_ctrl;

  localparam int IPU = 0, IPD = 1, LU = 2, LD = 3, APU = 4, APD = 5;
  localparam int INC = 6, DEC = 7, LOAD = 8, OUTS = 9;

  logic clk = 1'b0;
  logic rst_n, start, data_zero, ip_zero, out_ready, in_ack;
  logic [3:0] opcode;
  logic ip_up, ip_down, loop_up, loop_down, ap_up, ap_down;
  logic data_inc, data_dec, data_load, out_strobe, in_req, busy, halted, error;
  logic [13:0] outs_vec;

  bf_exec_ctrl #(.ROM_LATENCY(1), .LOOP_WIDTH(7), .MAX_DEPTH(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .data_zero(data_zero),
    .ip_zero(ip_zero), .out_ready(out_ready), .in_ack(in_ack), .ip_up(ip_up),
    .ip_down(ip_down), .loop_up(loop_up), .loop_down(loop_down), .ap_up(ap_up),
    .ap_down(ap_down), .data_inc(data_inc), .data_dec(data_dec), .data_load(data_load),
    .out_strobe(out_strobe), .in_req(in_req), .busy(busy), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, check_cnt = 0;
  string cname [10] = '{"ip_up", "ip_down", "loop_up", "loop_down", "ap_up", "ap_down",
                        "data_inc", "data_dec", "data_load", "out_strobe"};

  logic [3:0] prog [256];
  int         plen = 0;
  int         ip = 0, ap = 0;
  logic [7:0] mem [32];
  logic [7:0] inq [64];
  int         in_idx = 0;
  logic [7:0] outs [$];
  logic [7:0] e_outs [$];
  int         cnt [10];
  int         e [10];
  int         ipu_cyc [$];
  int         cyc = 0, viol = 0, depth_now = 0, depth_peak = 0;
  bit         auto_io = 1'b0;

  assign opcode    = (ip >= 0 && ip < plen) ? prog[ip] : 4'hF;
  assign ip_zero   = (ip == 0);
  assign data_zero = (mem[ap] == 8'd0);
  assign outs_vec  = {ip_up, ip_down, loop_up, loop_down, ap_up, ap_down, data_inc,
                      data_dec, data_load, out_strobe, in_req, busy, halted, error};

  // One clock cycle of the environment: sample pulses mid-cycle and move counters/tape.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if ((ip_up && ip_down) || (loop_up && loop_down) || (ap_up && ap_down) ||
        (data_inc && data_dec)) viol++;
    if (out_strobe) begin outs.push_back(mem[ap]); cnt[OUTS]++; end
    if (data_load) begin mem[ap] = (in_idx < 64) ? inq[in_idx] : 8'd0; in_idx++; cnt[LOAD]++; end
    if (data_inc) begin mem[ap] = mem[ap] + 8'd1; cnt[INC]++; end
    if (data_dec) begin mem[ap] = mem[ap] - 8'd1; cnt[DEC]++; end
    if (ap_up)   begin ap = (ap + 1) % 32;  cnt[APU]++; end
    if (ap_down) begin ap = (ap + 31) % 32; cnt[APD]++; end
    if (ip_up)   begin ip++; cnt[IPU]++; ipu_cyc.push_back(cyc); end
    if (ip_down) begin if (ip > 0) ip--; cnt[IPD]++; end
    if (loop_up)   begin depth_now++; cnt[LU]++; end
    if (loop_down) begin depth_now--; cnt[LD]++; end
    if (depth_now > depth_peak) depth_peak = depth_now;
    if (auto_io) begin
      out_ready = 1'($urandom_range(0, 1));
      in_ack    = in_req && ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic env_reset();
    ip = 0; ap = 0; in_idx = 0; cyc = 0; viol = 0; depth_now = 0; depth_peak = 0;
    for (int i = 0; i < 32; i++) mem[i] = 8'd0;
    for (int i = 0; i < 10; i++) cnt[i] = 0;
    outs.delete();
    ipu_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; in_ack = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    env_reset();
  endtask

  task automatic run_to_halt(input int budget, output bit timed_out);
    int n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!halted && n < budget) begin tick(); n++; end
    timed_out = !halted;
  endtask

  task automatic load_prog(input logic [3:0] p [$]);
    plen = p.size();
    for (int i = 0; i < plen; i++) prog[i] = p[i];
  endtask

  // Interpreter at the language level: brackets resolved through a precomputed match table.
  task automatic model_run(output bit ok);
    int mip = 0, map = 0, k = 0, steps = 0, sp = 0, m;
    int mt [256];
    int stk [256];
    logic [7:0] mm [32];
    logic [3:0] op;
    for (int i = 0; i < 32; i++) mm[i] = 8'd0;
    for (int i = 0; i < 10; i++) e[i] = 0;
    e_outs.delete();
    for (int i = 0; i < plen; i++) begin
      mt[i] = 0;
      if (prog[i] == 4'd5) begin stk[sp] = i; sp++; end
      else if (prog[i] == 4'd6) begin sp--; mt[i] = stk[sp]; mt[stk[sp]] = i; end
    end
    ok = 1'b1;
    while (ok) begin
      steps++;
      if (steps > 1500) begin ok = 1'b0; break; end
      op = (mip < plen) ? prog[mip] : 4'hF;
      if (op == 4'hF) break;
      case (op)
        4'd1: begin mm[map] = mm[map] + 8'd1; e[INC]++; e[IPU]++; mip++; end
        4'd2: begin mm[map] = mm[map] - 8'd1; e[DEC]++; e[IPU]++; mip++; end
        4'd3: begin map = (map + 1) % 32;  e[APU]++; e[IPU]++; mip++; end
        4'd4: begin map = (map + 31) % 32; e[APD]++; e[IPU]++; mip++; end
        4'd7: begin e_outs.push_back(mm[map]); e[OUTS]++; e[IPU]++; mip++; end
        4'd8: begin
          if (k >= 64) ok = 1'b0;
          else begin mm[map] = inq[k]; k++; e[LOAD]++; e[IPU]++; mip++; end
        end
        4'd5: begin
          if (mm[map] != 8'd0) begin e[IPU]++; mip++; end
          else begin
            m = mt[mip];
            for (int j = mip; j <= m; j++) begin
              if (prog[j] == 4'd5) e[LU]++;
              if (prog[j] == 4'd6) e[LD]++;
            end
            e[IPU] += m - mip + 1;
            mip = m + 1;
          end
        end
        4'd6: begin
          if (mm[map] == 8'd0) begin e[IPU]++; mip++; end
          else begin
            m = mt[mip];
            for (int j = m; j <= mip; j++) begin
              if (prog[j] == 4'd6) e[LU]++;
              if (prog[j] == 4'd5) e[LD]++;
            end
            e[IPD] += mip - m;
            e[IPU]++;
            mip = m + 1;
          end
        end
        default: begin e[IPU]++; mip++; end
      endcase
    end
  endtask

  task automatic gen_prog();
    logic [3:0] pick [10] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd11, 4'd2};
    int open = 0;
    int n = $urandom_range(12, 40);
    plen = 0;
    for (int i = 0; i < n; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 14 && open < 3) begin prog[plen] = 4'd5; plen++; open++; end
      else if (r < 28 && open > 0) begin prog[plen] = 4'd6; plen++; open--; end
      else begin prog[plen] = pick[$urandom_range(0, 9)]; plen++; end
    end
    while (open > 0) begin prog[plen] = 4'd6; plen++; open--; end
    prog[plen] = 4'hF;
    plen++;
    for (int i = 0; i < 64; i++) inq[i] = 8'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    check_cnt++;
    if (outs_vec !== 14'd0) $display("FAIL reset_hold: outputs %b, want all 0", outs_vec);
    else pass_cnt++;
    do_reset();
    @(negedge clk);
    check_cnt++;
    if (outs_vec !== 14'd0) $display("FAIL reset_idle: outputs %b, want all 0", outs_vec);
    else pass_cnt++;
  endtask

  task automatic test_simple();
    bit to;
    do_reset();
    load_prog('{4'd1, 4'd1, 4'd3, 4'd2, 4'hF});
    run_to_halt(200, to);
    check_cnt++;
    if (to) $display("FAIL simple_timeout: halted %b, want 1", halted); else pass_cnt++;
    check_cnt++;
    if (cnt[INC] != 2 || cnt[APU] != 1 || cnt[DEC] != 1 || cnt[IPU] != 4)
      $display("FAIL simple_counts: inc/apu/dec/ipu %0d/%0d/%0d/%0d, want 2/1/1/4",
               cnt[INC], cnt[APU], cnt[DEC], cnt[IPU]);
    else pass_cnt++;
    for (int i = 1; i < ipu_cyc.size(); i++) begin
      check_cnt++;
      if (ipu_cyc[i] - ipu_cyc[i-1] != 2)
        $display("FAIL simple_spacing: gap %0d, want 2", ipu_cyc[i] - ipu_cyc[i-1]);
      else pass_cnt++;
    end
    check_cnt++;
    if ({halted, busy, error} !== 3'b100)
      $display("FAIL simple_final: halted/busy/error %b, want 100", {halted, busy, error});
    else pass_cnt++;
  endtask

  task automatic test_nested_skip();
    bit to;
    do_reset();
    out_ready = 1'b1;
    load_prog('{4'd5, 4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd6, 4'd7, 4'hF});
    run_to_halt(300, to);
    check_cnt++;
    if (to || cnt[LU] != 2 || cnt[LD] != 2 || depth_peak != 2 || cnt[IPU] != 8)
      $display("FAIL skip_scan: lu/ld/peak/ipu %0d/%0d/%0d/%0d, want 2/2/2/8",
               cnt[LU], cnt[LD], depth_peak, cnt[IPU]);
    else pass_cnt++;
    check_cnt++;
    if (cnt[INC] != 0 || cnt[DEC] != 0 || cnt[OUTS] != 1 || error !== 1'b0)
      $display("FAIL skip_effects: inc/dec/out/err %0d/%0d/%0d/%b, want 0/0/1/0",
               cnt[INC], cnt[DEC], cnt[OUTS], error);
    else pass_cnt++;
  endtask

  task automatic test_back_scan();
    bit to;
    do_reset();
    load_prog('{4'd1, 4'd1, 4'd5, 4'd2, 4'd6, 4'hF});
    run_to_halt(300, to);
    check_cnt++;
    if (to || cnt[IPD] != 2 || cnt[IPU] != 7 || cnt[LU] != 1 || cnt[LD] != 1)
      $display("FAIL back_scan: ipd/ipu/lu/ld %0d/%0d/%0d/%0d, want 2/7/1/1",
               cnt[IPD], cnt[IPU], cnt[LU], cnt[LD]);
    else pass_cnt++;
    check_cnt++;
    if (cnt[DEC] != 2 || cnt[INC] != 2 || mem[0] != 8'd0 || error !== 1'b0)
      $display("FAIL back_resume: dec/inc/cell/err %0d/%0d/%0d/%b, want 2/2/0/0",
               cnt[DEC], cnt[INC], mem[0], error);
    else pass_cnt++;
  endtask

  task automatic test_input_wait();
    bit to;
    int n = 0;
    do_reset();
    load_prog('{4'd8, 4'hF});
    inq[0] = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!in_req && n < 20) begin tick(); n++; end
    check_cnt++;
    if (!in_req) $display("FAIL in_req_rise: in_req %b, want 1", in_req); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_cnt++;
      if (in_req !== 1'b1 || cnt[IPU] != 0)
        $display("FAIL in_wait_hold: in_req/ipu %b/%0d, want 1/0", in_req, cnt[IPU]);
      else pass_cnt++;
    end
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    check_cnt++;
    if ({data_load, ip_up, in_req} !== 3'b110)
      $display("FAIL in_ack_pulse: load/ipu/in_req %b, want 110", {data_load, ip_up, in_req});
    else pass_cnt++;
    n = 0;
    while (!halted && n < 20) begin tick(); n++; end
    check_cnt++;
    if (mem[0] !== 8'h5A || !halted)
      $display("FAIL in_value: cell %h halted %b, want 5a 1", mem[0], halted);
    else pass_cnt++;
  endtask

  task automatic test_bk_underflow();
    bit to;
    do_reset();
    load_prog('{4'd1, 4'd1, 4'd1, 4'd6, 4'hF});
    run_to_halt(300, to);
    check_cnt++;
    if ({halted, error, busy} !== 3'b110 || cnt[IPD] != 3 || cnt[LU] != 1 || cnt[LD] != 0)
      $display("FAIL bk_underflow: h/e/b %b ipd/lu/ld %0d/%0d/%0d, want 110 3/1/0",
               {halted, error, busy}, cnt[IPD], cnt[LU], cnt[LD]);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    bit to;
    logic [3:0] p [$];
    do_reset();
    for (int i = 0; i < 101; i++) p.push_back(4'd5);
    p.push_back(4'hF);
    load_prog(p);
    run_to_halt(2000, to);
    check_cnt++;
    if ({halted, error} !== 2'b11 || cnt[LU] != 100 || cnt[IPU] != 100 || cnt[LD] != 0)
      $display("FAIL depth_overflow: h/e %b lu/ipu/ld %0d/%0d/%0d, want 11 100/100/0",
               {halted, error}, cnt[LU], cnt[IPU], cnt[LD]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit to;
    int n = 0;
    logic [3:0] p [$];
    do_reset();
    p = '{4'd5, 4'd5, 4'd5};
    for (int i = 0; i < 40; i++) p.push_back(4'd1);
    p.push_back(4'd6); p.push_back(4'd6); p.push_back(4'd6); p.push_back(4'hF);
    load_prog(p);
    start = 1'b1;
    tick();
    start = 1'b0;
    while ((depth_now < 3 || !ip_up) && n < 400) begin tick(); n++; end
    check_cnt++;
    if (depth_now != 3 || !ip_up) $display("FAIL mid_reach: depth %0d ip_up %b, want 3 1", depth_now, ip_up);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    check_cnt++;
    if (outs_vec !== 14'd0) $display("FAIL mid_async: outputs %b, want all 0", outs_vec);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    env_reset();
    load_prog('{4'd1, 4'hF});
    start = 1'b1;
    tick();
    start = 1'b0;
    check_cnt++;
    if (busy !== 1'b1 || outs_vec[13:4] !== 10'd0)
      $display("FAIL restart_fetch: busy %b pulses %b, want 1 0", busy, outs_vec[13:4]);
    else pass_cnt++;
    n = 0;
    while (!halted && n < 50) begin tick(); n++; end
    check_cnt++;
    if (!halted || error || cnt[INC] != 1 || cnt[IPU] != 1 || cnt[LU] != 0 || cnt[LD] != 0)
      $display("FAIL restart_run: h/e %b%b inc/ipu/lu/ld %0d/%0d/%0d/%0d, want 10 1/1/0/0",
               halted, error, cnt[INC], cnt[IPU], cnt[LU], cnt[LD]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit ok, to;
    for (int it = 0; it < 8; it++) begin
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin gen_prog(); model_run(ok); end
      do_reset();
      auto_io = 1'b1;
      run_to_halt(20000, to);
      auto_io = 1'b0;
      in_ack = 1'b0;
      check_cnt++;
      if (to || error !== 1'b0 || viol != 0)
        $display("FAIL rand%0d_end: timeout %b error %b pair_viol %0d, want 0 0 0", it, to, error, viol);
      else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
        check_cnt++;
        if (cnt[i] != e[i]) $display("FAIL rand%0d_%s: got %0d, want %0d", it, cname[i], cnt[i], e[i]);
        else pass_cnt++;
      end
      check_cnt++;
      if (outs != e_outs) $display("FAIL rand%0d_out_bytes: got %0d bytes, want %0d", it, outs.size(), e_outs.size());
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_ack = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'd0;
    for (int i = 0; i < 10; i++) begin cnt[i] = 0; e[i] = 0; end
    test_reset();
    test_simple();
    test_nested_skip();
    test_back_scan();
    test_input_wait();
    test_bk_underflow();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
